// File: rtl/cache_ctrl_if.sv
// Core request/response and line-memory port bundle for cache_ctrl.
// master = core + memory side, slave = cache controller.
interface cache_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128
);
  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  req_ready;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with one line-wide memory port.
// Optional CACHE_CTRL_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned NUM_LINES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  cache_ctrl_if.slave bus
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int unsigned WORDS = LINE_WIDTH / 32;
  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned WA_W  = ADDR_WIDTH - 2;
  localparam int unsigned TAG_W = WA_W - OFF_W - IDX_W;
  localparam int unsigned LSB   = OFF_W + 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;

  state_t state, state_d;

  logic [NUM_LINES-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [LINE_WIDTH-1:0] data_q [NUM_LINES];

  logic            lat_write;
  logic [WA_W-1:0] lat_wa;
  logic [31:0]     lat_wdata;

  // Address being worked on: the live request in IDLE, the latched miss otherwise
  logic [WA_W-1:0]  cur_wa;
  logic [OFF_W-1:0] cur_off;
  logic [IDX_W-1:0] cur_idx;
  logic [TAG_W-1:0] cur_tag;
  logic             hit, hit_acc, miss_acc;

  logic                  req_ready_d, resp_valid_d, mem_req_d, mem_we_d;
  logic [31:0]           resp_rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_wdata_d;

  assign cur_wa  = (state == IDLE) ? bus.req_addr[ADDR_WIDTH-1:2] : lat_wa;
  assign cur_off = cur_wa[OFF_W-1:0];
  assign cur_idx = cur_wa[OFF_W +: IDX_W];
  assign cur_tag = cur_wa[WA_W-1 -: TAG_W];
  assign hit     = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

  // Next state plus the next value of every registered output
  always_comb begin
    state_d      = state;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    hit_acc      = 1'b0;
    miss_acc     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (hit) begin
            hit_acc      = 1'b1;
            resp_valid_d = 1'b1;
            if (!bus.req_write) resp_rdata_d = data_q[cur_idx][{cur_off, 5'd0} +: 32];
          end else begin
            miss_acc = 1'b1;
            state_d  = (valid_q[cur_idx] && dirty_q[cur_idx]) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: if (bus.mem_ready) state_d = REFILL;
      REFILL: begin
        if (bus.mem_ready) begin
          state_d      = RESPOND;
          resp_valid_d = 1'b1;
          if (!lat_write) resp_rdata_d = bus.mem_rdata[{cur_off, 5'd0} +: 32];
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Memory port is driven from the state being entered, so it holds steady until mem_ready
    case (state_d)
      WRITEBACK: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = {tag_q[cur_idx], cur_idx, {LSB{1'b0}}};
        mem_wdata_d = data_q[cur_idx];
      end
      REFILL: begin
        mem_req_d  = 1'b1;
        mem_addr_d = {cur_tag, cur_idx, {LSB{1'b0}}};
      end
      default: ;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State, line status bits and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      state          <= state_d;
      bus.req_ready  <= req_ready_d;
      bus.resp_valid <= resp_valid_d;
      bus.resp_rdata <= resp_rdata_d;
      bus.mem_req    <= mem_req_d;
      bus.mem_we     <= mem_we_d;
      bus.mem_addr   <= mem_addr_d;
      bus.mem_wdata  <= mem_wdata_d;
      if (hit_acc && bus.req_write) dirty_q[cur_idx] <= 1'b1;
      if (state == REFILL && bus.mem_ready) begin
        valid_q[cur_idx] <= 1'b1;
        dirty_q[cur_idx] <= 1'b0;
      end
      if (state == RESPOND && lat_write) dirty_q[cur_idx] <= 1'b1;
    end
  end

  // Tag/data array and miss latch; contents are meaningless until valid is set
  always_ff @(posedge clk) begin
    if (hit_acc && bus.req_write) data_q[cur_idx][{cur_off, 5'd0} +: 32] <= bus.req_wdata;
    if (miss_acc) begin
      lat_wa    <= cur_wa;
      lat_write <= bus.req_write;
      lat_wdata <= bus.req_wdata;
    end
    if (state == REFILL && bus.mem_ready) begin
      data_q[cur_idx] <= bus.mem_rdata;
      tag_q[cur_idx]  <= cur_tag;
    end
    if (state == RESPOND && lat_write) data_q[cur_idx][{cur_off, 5'd0} +: 32] <= lat_wdata;
  end

`ifdef CACHE_CTRL_STATS_EN
  // Saturating access statistics
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_acc && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      if (miss_acc && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: flat-memory reference model, randomized accesses,
// memory responder with random latency, plus directed reset/writeback scenarios.
module tb_cache_ctrl;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;
  localparam int unsigned NL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_ctrl_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_count, miss_count;
  cache_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .NUM_LINES(NL)) dut (
    .clk(clk), .reset(reset), .bus(bus), .hit_count(hit_count), .miss_count(miss_count));
`else
  cache_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .NUM_LINES(NL)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: memory is a flat word array; the cache must be invisible apart from timing.
  logic [31:0]   ref_mem [int unsigned];
  logic [LW-1:0] backing [int unsigned];

  function automatic logic [LW-1:0] init_line(input int unsigned la);
    logic [LW-1:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = (la + 32'(4*i)) ^ 32'hC0DE_0000;
    return l;
  endfunction

  function automatic logic [LW-1:0] mem_line(input int unsigned la);
    return backing.exists(la) ? backing[la] : init_line(la);
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned a);
    logic [LW-1:0] l;
    int unsigned k;
    if (ref_mem.exists(a)) return ref_mem[a];
    l = mem_line(a & ~32'hF);
    k = (a >> 2) & 3;
    return l[32*k +: 32];
  endfunction

  function automatic logic [LW-1:0] ref_line(input int unsigned la);
    logic [LW-1:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = ref_word(la + 32'(4*i));
    return l;
  endfunction

  // Which line is resident, tracked only to predict hit/miss
  bit          m_valid [NL];
  bit          m_dirty [NL];
  int unsigned m_tag   [NL];
  int          n_hits = 0, n_misses = 0;

  typedef struct {
    logic [31:0] rdata;
    bit          hit;
    int          acc;
  } exp_t;
  exp_t sb[$];

  int          cyc = 0;
  logic [31:0] last_resp;
  int          n_txn = 0;
  int          forced_delay = -1;
  logic [31:0] last_wb_addr, last_rf_addr;
  logic [LW-1:0] last_wb_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one access; returns one negedge after it was accepted.
  task automatic access(input bit wr, input int unsigned addr, input logic [31:0] wd);
    int waited = 0;
    bit done = 0;
    while (!done) begin
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      if (bus.req_ready) begin
        exp_t e;
        int unsigned ix, tg, wa;
        ix = (addr >> 4) % NL;
        tg = addr >> 6;
        wa = addr & ~32'h3;
        e.rdata = wr ? 32'h0 : ref_word(wa);
        if (wr) ref_mem[wa] = wd;
        e.hit = m_valid[ix] && (m_tag[ix] == tg);
        if (e.hit) begin
          n_hits++;
          if (wr) m_dirty[ix] = 1'b1;
        end else begin
          n_misses++;
          m_valid[ix] = 1'b1;
          m_tag[ix]   = tg;
          m_dirty[ix] = wr;
        end
        e.acc = cyc;
        sb.push_back(e);
        done = 1;
      end
      @(negedge clk);
      if (!done) begin
        waited++;
        if (waited > 300) begin
          chk("accept_timeout", 128'(bus.req_ready), 128'(1));
          done = 1;
        end
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() == 0 && bus.req_ready && !bus.mem_req) break;
      n++;
      if (n > 500) begin
        chk("idle_timeout", 128'(sb.size()), 128'(0));
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb.delete();
    ref_mem.delete();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    n_hits = 0;
    n_misses = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_req_ready", 128'(bus.req_ready), 128'(1));
    chk("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    chk("rst_mem_req", 128'(bus.mem_req), 128'(0));
  endtask

  // Monitor: pops the scoreboard on each response and checks idle-output rules
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        if (!bus.resp_valid) chk("rdata_when_idle", 128'(bus.resp_rdata), 128'(0));
        if (!bus.mem_req) begin
          chk("mem_we_when_idle", 128'(bus.mem_we), 128'(0));
          chk("mem_addr_when_idle", 128'(bus.mem_addr), 128'(0));
          chk("mem_wdata_when_idle", bus.mem_wdata, 128'(0));
        end else begin
          chk("req_ready_during_mem", 128'(bus.req_ready), 128'(0));
        end
        if (bus.resp_valid) begin
          if (sb.size() == 0) begin
            chk("spurious_resp", 128'(bus.resp_valid), 128'(0));
          end else begin
            exp_t e;
            e = sb.pop_front();
            last_resp = bus.resp_rdata;
            chk("resp_rdata", 128'(bus.resp_rdata), 128'(e.rdata));
            if (e.hit) chk("hit_latency", 128'(cyc - e.acc), 128'(1));
            else begin
              chk("miss_latency_min", 128'((cyc - e.acc) >= 2), 128'(1));
              chk("req_ready_in_respond", 128'(bus.req_ready), 128'(0));
            end
          end
        end
      end
    end
  end

  // Memory responder with random (or forced) latency
  initial begin
    bit busy = 0;
    int cnt = 0;
    logic t_we;
    logic [31:0] t_addr;
    logic [LW-1:0] t_wdata;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        busy = 0;
      end
      if (!bus.mem_req) begin
        busy = 0;
      end else begin
        if (!busy) begin
          busy = 1;
          t_we = bus.mem_we;
          t_addr = bus.mem_addr;
          t_wdata = bus.mem_wdata;
          cnt = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 3));
          n_txn++;
          chk("mem_addr_aligned", 128'(t_addr[3:0]), 128'(0));
        end else begin
          chk("mem_addr_stable", 128'(bus.mem_addr), 128'(t_addr));
          chk("mem_we_stable", 128'(bus.mem_we), 128'(t_we));
          chk("mem_wdata_stable", bus.mem_wdata, t_wdata);
        end
        if (cnt == 0) begin
          bus.mem_ready = 1'b1;
          if (t_we) begin
            chk("writeback_data", bus.mem_wdata, ref_line(t_addr));
            backing[t_addr] = bus.mem_wdata;
            last_wb_addr = t_addr;
            last_wb_data = bus.mem_wdata;
          end else begin
            bus.mem_rdata = mem_line(t_addr);
            last_rf_addr = t_addr;
          end
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_req_ready", 128'(bus.req_ready), 128'(1));
    chk("reset_resp_valid", 128'(bus.resp_valid), 128'(0));
    chk("reset_mem_req", 128'(bus.mem_req), 128'(0));
    chk("reset_mem_addr", 128'(bus.mem_addr), 128'(0));
    @(negedge clk);

    // First load refills line 0x40
    backing[32'h40] = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
    access(0, 32'h40, 32'h0);
    wait_idle();
    chk("first_refill_addr", 128'(last_rf_addr), 128'h40);
    chk("first_load_data", 128'(last_resp), 128'h0000AAAA);

    saved = n_txn;
    access(0, 32'h40, 32'h0);
    wait_idle();
    chk("hit_no_traffic", 128'(n_txn), 128'(saved));

    access(1, 32'h44, 32'h1234_5678);
    access(0, 32'h44, 32'h0);
    wait_idle();
    chk("store_load_no_traffic", 128'(n_txn), 128'(saved));
    chk("store_then_load", 128'(last_resp), 128'h1234_5678);

    // Conflict on index 0 forces writeback of the dirty 0x40 line
    access(0, 32'h80, 32'h0);
    wait_idle();
    chk("wb_addr", 128'(last_wb_addr), 128'h40);
    chk("wb_word1", 128'(last_wb_data[63:32]), 128'h1234_5678);
    chk("refill_after_wb", 128'(last_rf_addr), 128'h80);

    // Long refill stall, then reset in the middle of it
    forced_delay = 20;
    access(0, 32'h100, 32'h0);
    repeat (5) @(negedge clk);
    #1;
    chk("stall_mem_req", 128'(bus.mem_req), 128'(1));
    chk("stall_req_ready", 128'(bus.req_ready), 128'(0));
    do_reset();
    forced_delay = -1;
    repeat (3) @(negedge clk);

    // 3 hits and 2 misses straight after reset
    access(0, 32'h200, 32'h0);
    access(0, 32'h200, 32'h0);
    access(1, 32'h204, 32'hCAFE_F00D);
    access(0, 32'h300, 32'h0);
    access(0, 32'h308, 32'h0);
    wait_idle();
`ifdef CACHE_CTRL_STATS_EN
    chk("stats_hits", 128'(hit_count), 128'(3));
    chk("stats_misses", 128'(miss_count), 128'(2));
`endif

    saved = n_txn;
    access(0, 32'h40, 32'h0);
    wait_idle();
    chk("miss_after_reset", 128'(last_rf_addr), 128'h40);
    chk("miss_after_reset_traffic", 128'(n_txn > saved), 128'(1));

    // Randomized mixed traffic over 8 tags per index
    for (int i = 0; i < 400; i++) begin
      int unsigned a;
      bit w;
      a = ($urandom_range(0, 127) * 4) + $urandom_range(0, 3);
      w = ($urandom_range(0, 9) < 4);
      access(w, a, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    wait_idle();
`ifdef CACHE_CTRL_STATS_EN
    chk("final_hits", 128'(hit_count), 128'(n_hits));
    chk("final_misses", 128'(miss_count), 128'(n_misses));
`endif
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
